// File: rtl/sensor_align_pkg.sv
// Shared types and constants for the sensor lane alignment blocks.
package sensor_align_pkg;

    localparam int TAP_NUM = 32;
    localparam int TAP_W   = 5;
    localparam int ERR_W   = 8;
    // Wide enough for any practical settle or check window length.
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RECORD = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } scan_state_e;

    // Complete register state of the tap scanner; every output is a field here.
    typedef struct packed {
        scan_state_e          state;
        logic [TAP_W-1:0]     tap;
        logic [CNT_W-1:0]     cnt;
        logic [ERR_W-1:0]     err;
        logic [TAP_NUM-1:0]   mask;
        logic [TAP_NUM-1:0]   lock_mask;
        logic                 load;
        logic                 busy;
        logic                 done;
    } scan_regs_t;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/idelay_tap_scan_if.sv
// Lane input, delay-element control and lock-mask result signals of the tap scanner.
interface idelay_tap_scan_if
    import sensor_align_pkg::*;
#(
    parameter int DATA_W = 10
) ();

    logic                start;
    logic [DATA_W-1:0]   din;
    logic                din_valid;
    logic [TAP_W-1:0]    delay_tap_out;
    logic                delay_load_out;
    logic                busy_out;
    logic [TAP_NUM-1:0]  lock_mask_dout;
    logic                done_out;

    // Controller / bench side: drives the lane and observes the result.
    modport master (
        output start, din, din_valid,
        input  delay_tap_out, delay_load_out, busy_out, lock_mask_dout, done_out
    );

    // Scanner side.
    modport slave (
        input  start, din, din_valid,
        output delay_tap_out, delay_load_out, busy_out, lock_mask_dout, done_out
    );

endinterface

// File: rtl/idelay_tap_scan.sv
// Sweeps all 32 input-delay taps, scores a training word at each one and
// publishes the per-tap pass/fail verdicts as a 32-bit lock mask.
module idelay_tap_scan
    import sensor_align_pkg::*;
#(
    parameter string             DEBUG         = "FALSE",
    parameter int                DATA_W        = 10,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 10'h3A6,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                CHECK_CYCLES  = 64,
    parameter logic [ERR_W-1:0]  MAX_ERR       = 8'd0
) (
    input  logic               px_clk,
    input  logic               px_reset,
    idelay_tap_scan_if.slave   bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_NUM - 1);

    scan_regs_t          scan_reg;
    scan_regs_t          scan_next;
    logic [TAP_NUM-1:0]  rec_hit;
    logic                tap_pass;

    // One-hot write enable into the working mask for the tap being recorded.
    genvar gi;
    generate
        for (gi = 0; gi < TAP_NUM; gi++) begin : g_rec_hit
            assign rec_hit[gi] = (scan_reg.state == ST_RECORD) && (scan_reg.tap == TAP_W'(gi));
        end
    endgenerate

    assign tap_pass = (scan_reg.err <= MAX_ERR);

    // Next-state logic; load and done are single-cycle strobes that default low.
    always_comb begin
        scan_next      = scan_reg;
        scan_next.load = 1'b0;
        scan_next.done = 1'b0;
        case (scan_reg.state)
            ST_IDLE: begin
                if (bus.start) begin
                    scan_next.tap   = '0;
                    scan_next.mask  = '0;
                    scan_next.load  = 1'b1;
                    scan_next.busy  = 1'b1;
                    scan_next.state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                scan_next.cnt   = '0;
                scan_next.state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (scan_reg.cnt == SETTLE_LAST) begin
                    scan_next.cnt   = '0;
                    scan_next.err   = '0;
                    scan_next.state = ST_CHECK;
                end else begin
                    scan_next.cnt = scan_reg.cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                if (bus.din_valid) begin
                    scan_next.cnt = scan_reg.cnt + 1'b1;
                    if (bus.din != TRAIN_PATTERN) begin
                        scan_next.err = sat_inc(scan_reg.err);
                    end
                    if (scan_reg.cnt == CHECK_LAST) begin
                        scan_next.state = ST_RECORD;
                    end
                end
            end
            ST_RECORD: begin
                scan_next.mask  = (scan_reg.mask & ~rec_hit) | (rec_hit & {TAP_NUM{tap_pass}});
                scan_next.state = ST_NEXT;
            end
            ST_NEXT: begin
                if (scan_reg.tap == TAP_LAST) begin
                    scan_next.state = ST_DONE;
                end else begin
                    scan_next.tap   = scan_reg.tap + 1'b1;
                    scan_next.load  = 1'b1;
                    scan_next.state = ST_LOAD;
                end
            end
            ST_DONE: begin
                scan_next.lock_mask = scan_reg.mask;
                scan_next.done      = 1'b1;
                scan_next.busy      = 1'b0;
                scan_next.state     = ST_IDLE;
            end
            default: begin
                scan_next.busy  = 1'b0;
                scan_next.state = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops the partial scan and every output.
    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            scan_reg <= '0;
        end else begin
            scan_reg <= scan_next;
        end
    end

    assign bus.delay_tap_out  = scan_reg.tap;
    assign bus.delay_load_out = scan_reg.load;
    assign bus.busy_out       = scan_reg.busy;
    assign bus.lock_mask_dout = scan_reg.lock_mask;
    assign bus.done_out       = scan_reg.done;

    // Optional consistency probes on the strobes.
    generate
        if (DEBUG == "TRUE") begin : g_debug
            // Strobes must only appear in the states that own them.
            always_ff @(posedge px_clk) begin
                if (!px_reset) begin
                    assert (!scan_reg.load || scan_reg.state == ST_LOAD);
                    assert (!scan_reg.done || scan_reg.state == ST_IDLE);
                end
            end
        end
    endgenerate

endmodule
